// File: rtl/bsg_manycore_edge_mem_responder_if.sv
// rtl/bsg_manycore_edge_mem_responder_if.sv - mesh link bundle between a router and the edge memory responder
interface bsg_manycore_edge_mem_responder_if #(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 3,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 12
);
    localparam int load_id_width_lp = 5;
    localparam int mask_width_lp    = data_width_p / 8;
    localparam int fwd_width_lp     = addr_width_p + 2 + mask_width_lp + load_id_width_lp
                                    + data_width_p + 2 * (x_cord_width_p + y_cord_width_p);
    localparam int rev_width_lp     = 2 + data_width_p + load_id_width_lp
                                    + x_cord_width_p + y_cord_width_p;

    // Forward requests travelling from the router into the responder
    logic                    fwd_v;
    logic [fwd_width_lp-1:0] fwd_data;
    logic                    fwd_ready;

    // Reverse responses travelling from the responder back to the router
    logic                    rev_v;
    logic [rev_width_lp-1:0] rev_data;
    logic                    rev_ready;

    // Responder-originated forward traffic (never used by a pure responder)
    logic                    out_fwd_v;
    logic [fwd_width_lp-1:0] out_fwd_data;
    logic                    out_fwd_ready;

    // Router-originated reverse traffic arriving at the edge (always sunk)
    logic                    in_rev_v;
    logic [rev_width_lp-1:0] in_rev_data;
    logic                    in_rev_ready;

    modport master (
        output fwd_v, fwd_data, rev_ready, out_fwd_ready, in_rev_v, in_rev_data,
        input  fwd_ready, rev_v, rev_data, out_fwd_v, out_fwd_data, in_rev_ready
    );

    modport slave (
        input  fwd_v, fwd_data, rev_ready, out_fwd_ready, in_rev_v, in_rev_data,
        output fwd_ready, rev_v, rev_data, out_fwd_v, out_fwd_data, in_rev_ready
    );
endinterface

// File: rtl/bsg_manycore_edge_mem_responder.sv
// rtl/bsg_manycore_edge_mem_responder.sv - edge-of-array memory responder terminating one mesh link
module bsg_manycore_edge_mem_responder #(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 3,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 12,
    parameter int mem_words_p    = 1024,
    parameter int fifo_els_p     = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bsg_manycore_edge_mem_responder_if.slave link_sif,
    input  logic [x_cord_width_p-1:0]     my_x_i,
    input  logic [y_cord_width_p-1:0]     my_y_i,
    output logic [15:0]                   err_count_o
);
    localparam int load_id_width_lp = 5;
    localparam int mask_width_lp    = data_width_p / 8;
    localparam int fwd_width_lp     = addr_width_p + 2 + mask_width_lp + load_id_width_lp
                                    + data_width_p + 2 * (x_cord_width_p + y_cord_width_p);
    localparam int sram_aw_lp       = $clog2(mem_words_p);
    localparam int ptr_w_lp         = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp         = $clog2(fifo_els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

    localparam logic [1:0] op_load_lp      = 2'd0;
    localparam logic [1:0] op_store_lp     = 2'd1;
    localparam logic [1:0] rsp_credit_lp   = 2'd0;
    localparam logic [1:0] rsp_int_load_lp = 2'd1;

    typedef struct packed {
        logic [addr_width_p-1:0]     addr;
        logic [1:0]                  op;
        logic [mask_width_lp-1:0]    mask;
        logic [load_id_width_lp-1:0] load_id;
        logic [data_width_p-1:0]     payload;
        logic [y_cord_width_p-1:0]   src_y;
        logic [x_cord_width_p-1:0]   src_x;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        logic [1:0]                  pkt_type;
        logic [data_width_p-1:0]     data;
        logic [load_id_width_lp-1:0] load_id;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
    } rev_pkt_s;

    // What survives of a request once it leaves the FIFO and the SRAM has been driven
    typedef struct packed {
        logic                        is_load;
        logic                        bad;
        logic [load_id_width_lp-1:0] load_id;
        logic [y_cord_width_p-1:0]   src_y;
        logic [x_cord_width_p-1:0]   src_x;
    } req_info_s;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [fwd_width_lp-1:0] fifo_mem [fifo_els_p];
    logic [ptr_w_lp-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]     count_q, count_d;
    logic                    ready_en_q, ready_en_d;

    logic [data_width_p-1:0] sram_mem [mem_words_p];
    logic [data_width_p-1:0] sram_rdata_q;

    req_info_s   req_q, req_d;
    rev_pkt_s    rsp_q, rsp_d;
    logic [15:0] err_count_q, err_count_d;

    logic     fwd_ready;
    logic     fifo_empty;
    logic     push;
    logic     pop;
    logic     rev_v;
    logic     rsp_load;
    fwd_pkt_s head;
    logic     head_oob;
    logic     head_is_load;
    logic     head_is_store;
    logic     head_bad;
    logic     sram_we;
    logic     sram_re;
    logic [sram_aw_lp-1:0] sram_idx;

    // Ready is held low out of reset and uses pre-pop fullness, so a full FIFO never accepts
    assign fwd_ready  = ready_en_q & (count_q != full_cnt_lp);
    assign fifo_empty = (count_q == '0);
    assign push       = link_sif.fwd_v & fwd_ready;
    assign head       = fifo_mem[rd_ptr_q];

    assign link_sif.fwd_ready    = fwd_ready;
    assign link_sif.rev_v        = rev_v;
    assign link_sif.rev_data     = rsp_q;
    assign link_sif.out_fwd_v    = 1'b0;
    assign link_sif.out_fwd_data = '0;
    assign link_sif.in_rev_ready = 1'b1;
    assign err_count_o           = err_count_q;

    logic unused_inputs;
    assign unused_inputs = ^{my_x_i, my_y_i, head.x_cord, head.y_cord,
                             link_sif.in_rev_v, link_sif.in_rev_data, link_sif.out_fwd_ready};

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: SRAM is driven on the way into ACCESS, the response is held in RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (link_sif.rev_ready) state_d = fifo_empty ? ST_IDLE : ST_ACCESS;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: pop the FIFO head on every transition into ACCESS
    always_comb begin
        pop      = 1'b0;
        rev_v    = 1'b0;
        rsp_load = 1'b0;
        case (state_q)
            ST_IDLE:   pop = !fifo_empty;
            ST_ACCESS: rsp_load = 1'b1;
            ST_RESP: begin
                rev_v = 1'b1;
                pop   = link_sif.rev_ready & !fifo_empty;
            end
            default: ;
        endcase
    end

    // Decode the FIFO head and derive the SRAM strobes for the popped request
    always_comb begin
        head_oob      = 32'(head.addr) >= 32'(mem_words_p);
        head_is_load  = (head.op == op_load_lp);
        head_is_store = (head.op == op_store_lp);
        head_bad      = head_oob | !(head_is_load | head_is_store);
        sram_we       = pop & head_is_store & !head_bad;
        sram_re       = pop & head_is_load & !head_bad;
        sram_idx      = head.addr[sram_aw_lp-1:0];
    end

    // FIFO pointer, occupancy and ready-enable next values
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ready_en_d = 1'b1;
        if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
        count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end

    // FIFO control registers; reset empties the queue and drops anything pending
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= link_sif.fwd_data;
    end

    // Single-port sync SRAM with byte-masked writes; not reset
    always_ff @(posedge clk_i) begin
        if (sram_we) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (head.mask[b]) sram_mem[sram_idx][b*8 +: 8] <= head.payload[b*8 +: 8];
            end
        end
        if (sram_re) sram_rdata_q <= sram_mem[sram_idx];
    end

    // Request info, response payload and error counter next values
    always_comb begin
        req_d = req_q;
        if (pop) begin
            req_d.is_load = head_is_load;
            req_d.bad     = head_bad;
            req_d.load_id = head.load_id;
            req_d.src_y   = head.src_y;
            req_d.src_x   = head.src_x;
        end

        rsp_d = rsp_q;
        if (rsp_load) begin
            rsp_d.pkt_type = req_q.is_load ? rsp_int_load_lp : rsp_credit_lp;
            rsp_d.data     = (req_q.is_load && !req_q.bad) ? sram_rdata_q : '0;
            rsp_d.load_id  = req_q.load_id;
            rsp_d.y_cord   = req_q.src_y;
            rsp_d.x_cord   = req_q.src_x;
        end

        err_count_d = err_count_q;
        if (rsp_load && req_q.bad && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end

    // Datapath registers; the response stays frozen for the whole of RESP
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_q       <= '0;
            rsp_q       <= '0;
            err_count_q <= '0;
        end else begin
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_edge_mem_responder.sv
// tb/tb_bsg_manycore_edge_mem_responder.sv - directed self-checking bench for the edge memory responder
module tb_bsg_manycore_edge_mem_responder;
    localparam int X     = 4;
    localparam int Y     = 3;
    localparam int D     = 32;
    localparam int A     = 12;
    localparam int MEM   = 64;
    localparam int FIFO  = 2;
    localparam int M     = D / 8;
    localparam int LID   = 5;
    localparam int FWD_W = A + 2 + M + LID + D + 2 * (X + Y);
    localparam int REV_W = 2 + D + LID + X + Y;

    localparam logic [1:0] OP_LD  = 2'd0;
    localparam logic [1:0] OP_ST  = 2'd1;
    localparam logic [1:0] OP_AMO = 2'd2;
    localparam logic [1:0] T_CRED = 2'd0;
    localparam logic [1:0] T_LOAD = 2'd1;
    localparam logic [X-1:0] MY_X = 4'd2;
    localparam logic [Y-1:0] MY_Y = 3'd1;

    logic        clk;
    logic        reset_n_i;
    logic [15:0] err_count;
    logic [X-1:0] my_x;
    logic [Y-1:0] my_y;

    int n_vec;
    int n_miss;

    bsg_manycore_edge_mem_responder_if #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .data_width_p(D), .addr_width_p(A)
    ) link_sif ();

    bsg_manycore_edge_mem_responder #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .data_width_p(D), .addr_width_p(A),
        .mem_words_p(MEM), .fifo_els_p(FIFO)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .link_sif   (link_sif),
        .my_x_i     (my_x),
        .my_y_i     (my_y),
        .err_count_o(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FWD_W-1:0] mk_req(input logic [1:0] op, input logic [A-1:0] addr,
                                                input logic [M-1:0] mask, input logic [D-1:0] data,
                                                input logic [LID-1:0] id, input logic [X-1:0] sx,
                                                input logic [Y-1:0] sy);
        return {addr, op, mask, id, data, sy, sx, MY_Y, MY_X};
    endfunction

    function automatic logic [REV_W-1:0] mk_rsp(input logic [1:0] t, input logic [D-1:0] d,
                                                input logic [LID-1:0] id, input logic [X-1:0] x,
                                                input logic [Y-1:0] y);
        return {t, d, id, y, x};
    endfunction

    task automatic send(input logic [FWD_W-1:0] pkt);
        int w;
        w = 0;
        link_sif.fwd_data = pkt;
        link_sif.fwd_v    = 1'b1;
        while (!link_sif.fwd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("send_ready", 64'(link_sif.fwd_ready), 64'(1));
        @(posedge clk); #1;
        link_sif.fwd_v = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [REV_W-1:0] exp);
        int w;
        w = 0;
        while (!link_sif.rev_v && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check_val({tag, "_v"}, 64'(link_sif.rev_v), 64'(1));
        check_val(tag, 64'(link_sif.rev_data), 64'(exp));
        link_sif.rev_ready = 1'b1;
        @(posedge clk); #1;
        link_sif.rev_ready = 1'b0;
    endtask

    task automatic lat_check(input string tag, input logic [FWD_W-1:0] pkt, input logic [REV_W-1:0] exp);
        link_sif.rev_ready = 1'b1;
        send(pkt);
        check_val({tag, "_n0"}, 64'(link_sif.rev_v), 64'(0));
        @(posedge clk); #1;
        check_val({tag, "_n1"}, 64'(link_sif.rev_v), 64'(0));
        @(posedge clk); #1;
        check_val({tag, "_n2"}, 64'(link_sif.rev_v), 64'(1));
        check_val({tag, "_data"}, 64'(link_sif.rev_data), 64'(exp));
        @(posedge clk); #1;
        check_val({tag, "_drain"}, 64'(link_sif.rev_v), 64'(0));
        link_sif.rev_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [FWD_W-1:0] pkts [4];
        logic [REV_W-1:0] first_rsp;
        logic             seen;
        int               k;
        int               stale;
        logic             acc;

        n_vec = 0;
        n_miss = 0;
        reset_n_i = 1'b0;
        my_x = MY_X;
        my_y = MY_Y;
        link_sif.fwd_v = 1'b0;
        link_sif.fwd_data = '0;
        link_sif.rev_ready = 1'b0;
        link_sif.out_fwd_ready = 1'b0;
        link_sif.in_rev_v = 1'b0;
        link_sif.in_rev_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rev_v", 64'(link_sif.rev_v), 64'(0));
        check_val("rst_fwd_ready", 64'(link_sif.fwd_ready), 64'(0));
        check_val("rst_err", 64'(err_count), 64'(0));
        check_val("rst_out_fwd_v", 64'(link_sif.out_fwd_v), 64'(0));
        check_val("rst_in_rev_ready", 64'(link_sif.in_rev_ready), 64'(1));
        reset_n_i = 1'b1;
        @(posedge clk); #1;

        // Seed words 0..3 with known values
        for (int i = 0; i < 4; i++) begin
            send(mk_req(OP_ST, A'(i), 4'hF, 32'h11110000 + 32'(i), LID'(i), 4'd1, 3'd2));
            recv("seed_credit", mk_rsp(T_CRED, 32'h0, LID'(i), 4'd1, 3'd2));
        end

        // Full-word store then load
        send(mk_req(OP_ST, 12'h010, 4'hF, 32'hCAFEF00D, 5'd3, 4'd5, 3'd6));
        send(mk_req(OP_LD, 12'h010, 4'h0, 32'h0, 5'd17, 4'd5, 3'd6));
        recv("t1_credit", mk_rsp(T_CRED, 32'h0, 5'd3, 4'd5, 3'd6));
        recv("t1_load", mk_rsp(T_LOAD, 32'hCAFEF00D, 5'd17, 4'd5, 3'd6));

        // Byte-masked partial store
        send(mk_req(OP_ST, 12'h005, 4'hF, 32'hFFFFFFFF, 5'd1, 4'd7, 3'd0));
        send(mk_req(OP_ST, 12'h005, 4'b0001, 32'h00000012, 5'd2, 4'd7, 3'd0));
        send(mk_req(OP_LD, 12'h005, 4'h0, 32'h0, 5'd30, 4'd7, 3'd0));
        recv("t2_credit_a", mk_rsp(T_CRED, 32'h0, 5'd1, 4'd7, 3'd0));
        recv("t2_credit_b", mk_rsp(T_CRED, 32'h0, 5'd2, 4'd7, 3'd0));
        recv("t2_load", mk_rsp(T_LOAD, 32'hFFFFFF12, 5'd30, 4'd7, 3'd0));

        // Zero-stall latency into an idle block
        lat_check("t3", mk_req(OP_LD, 12'h010, 4'h0, 32'h0, 5'd9, 4'd3, 3'd4),
                  mk_rsp(T_LOAD, 32'hCAFEF00D, 5'd9, 4'd3, 3'd4));

        // Backpressure: four loads against a stalled reverse channel
        for (int i = 0; i < 4; i++) pkts[i] = mk_req(OP_LD, A'(i), 4'h0, 32'h0, LID'(i + 1), 4'd8, 3'd5);
        k = 0;
        seen = 1'b0;
        first_rsp = '0;
        for (int c = 0; c < 20; c++) begin
            if (k < 4) begin
                link_sif.fwd_data = pkts[k];
                link_sif.fwd_v = 1'b1;
            end else begin
                link_sif.fwd_v = 1'b0;
            end
            acc = link_sif.fwd_ready && (k < 4);
            @(posedge clk); #1;
            if (acc) k++;
            if (link_sif.rev_v && !seen) begin
                seen = 1'b1;
                first_rsp = link_sif.rev_data;
            end
        end
        check_val("t4_accepts", 64'(k), 64'(FIFO + 1));
        check_val("t4_fwd_ready", 64'(link_sif.fwd_ready), 64'(0));
        check_val("t4_first", 64'(first_rsp), 64'(mk_rsp(T_LOAD, 32'h11110000, 5'd1, 4'd8, 3'd5)));
        check_val("t4_hold", 64'(link_sif.rev_data), 64'(mk_rsp(T_LOAD, 32'h11110000, 5'd1, 4'd8, 3'd5)));
        fork
            send(pkts[3]);
            begin
                for (int j = 0; j < 4; j++)
                    recv("t4_order", mk_rsp(T_LOAD, 32'h11110000 + 32'(j), LID'(j + 1), 4'd8, 3'd5));
            end
        join

        // Out-of-range and unsupported requests
        send(mk_req(OP_LD, A'(MEM), 4'h0, 32'h0, 5'd10, 4'd1, 3'd1));
        send(mk_req(OP_ST, A'(MEM + 3), 4'hF, 32'hDEADBEEF, 5'd11, 4'd1, 3'd1));
        recv("t5_oob_load", mk_rsp(T_LOAD, 32'h0, 5'd10, 4'd1, 3'd1));
        recv("t5_oob_store", mk_rsp(T_CRED, 32'h0, 5'd11, 4'd1, 3'd1));
        check_val("t5_err2", 64'(err_count), 64'(2));
        send(mk_req(OP_AMO, 12'h002, 4'hF, 32'hA5A5A5A5, 5'd12, 4'd1, 3'd1));
        recv("t5_amo", mk_rsp(T_CRED, 32'h0, 5'd12, 4'd1, 3'd1));
        check_val("t5_err3", 64'(err_count), 64'(3));
        for (int i = 0; i < 4; i++) begin
            send(mk_req(OP_LD, A'(i), 4'h0, 32'h0, LID'(20 + i), 4'd2, 3'd3));
            recv("t5_unchanged", mk_rsp(T_LOAD, 32'h11110000 + 32'(i), LID'(20 + i), 4'd2, 3'd3));
        end

        // Reset while a response is pending
        send(mk_req(OP_LD, 12'h001, 4'h0, 32'h0, 5'd5, 4'd6, 3'd2));
        k = 0;
        while (!link_sif.rev_v && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("t6_pending", 64'(link_sif.rev_v), 64'(1));
        reset_n_i = 1'b0;
        #1;
        check_val("t6_async_rev_v", 64'(link_sif.rev_v), 64'(0));
        check_val("t6_fwd_ready", 64'(link_sif.fwd_ready), 64'(0));
        check_val("t6_err_clr", 64'(err_count), 64'(0));
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        check_val("t6_ready_hold", 64'(link_sif.fwd_ready), 64'(0));
        link_sif.rev_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (link_sif.rev_v) stale++;
        end
        check_val("t6_no_stale", 64'(stale), 64'(0));
        link_sif.rev_ready = 1'b0;
        lat_check("t6_lat", mk_req(OP_LD, 12'h010, 4'h0, 32'h0, 5'd14, 4'd9, 3'd7),
                  mk_rsp(T_LOAD, 32'hCAFEF00D, 5'd14, 4'd9, 3'd7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
